// File: rtl/nivel_sensor_cond.sv
// -----------------------------------------------------------------------------
// nivel_sensor_cond
//   Input conditioner for the irrigation tank level probes. Each raw probe
//   (high A, mid M, low B) is brought into the clk domain through a 2-flop
//   synchroniser and then debounced. The debounced combination is decoded
//   into a tank level, and a small FSM tracks that level. An invalid
//   combination that persists raises a sticky fault, which is cleared by an
//   acknowledge that coincides with a valid combination.
//
// Parameters
//   DEB_CYCLES   : consecutive agreeing synchronised samples needed to flip a
//                  debounced probe value (>= 1)
//   ALARM_CYCLES : consecutive invalid debounced cycles before FALHA (>= 1)
//
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   sA/sM/sB  in  raw high/mid/low probes, 1 = water present, asynchronous
//   ack       in  alarm acknowledge, synchronous, level-sampled
//   A/M/B     out conditioned level code (held last valid level during FALHA)
//   alarm     out probe-fault alarm, high while in FALHA
//   valor_0   out tank empty indication (effective level is VAZIO)
//   level_chg out one-cycle pulse on each accepted level change
// -----------------------------------------------------------------------------
module nivel_sensor_cond #(
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned ALARM_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sA,
  input  logic sM,
  input  logic sB,
  input  logic ack,
  output logic A,
  output logic M,
  output logic B,
  output logic alarm,
  output logic valor_0,
  output logic level_chg
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned IW = $clog2(ALARM_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [IW-1:0] INV_LAST = IW'(ALARM_CYCLES - 1);

  typedef enum logic [2:0] {
    VAZIO = 3'd0,
    BAIXO = 3'd1,
    MEDIO = 3'd2,
    ALTO  = 3'd3,
    FALHA = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser: bit 2 = A, bit 1 = M, bit 0 = B
  // ---------------------------------------------------------------------------
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  assign w_raw = {sA, sM, sB};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce, one independent counter per probe
  // ---------------------------------------------------------------------------
  logic [2:0] r_deb;

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_deb[g] <= 1'b0;
      end else if (r_sync2[g] == r_deb[g]) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        // The DEB_CYCLES-th disagreeing sample flips the debounced value.
        r_cnt    <= '0;
        r_deb[g] <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combination decode
  // ---------------------------------------------------------------------------
  logic   w_code_valid;
  state_t w_code_lvl;

  always_comb begin
    w_code_valid = 1'b1;
    w_code_lvl   = VAZIO;
    case (r_deb)
      3'b000:  w_code_lvl = VAZIO;
      3'b001:  w_code_lvl = BAIXO;
      3'b011:  w_code_lvl = MEDIO;
      3'b111:  w_code_lvl = ALTO;
      default: w_code_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Level FSM
  //   r_level always holds the last valid level, so during FALHA it is the
  //   level shown on A/M/B and the reference for deciding whether the exit
  //   counts as a level change.
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nx;
  state_t        r_level;
  state_t        w_level_nx;
  logic [IW-1:0] r_inv_cnt;
  logic [IW-1:0] w_inv_cnt_nx;
  logic          r_chg;
  logic          w_chg_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= VAZIO;
      r_level   <= VAZIO;
      r_inv_cnt <= '0;
      r_chg     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_level   <= w_level_nx;
      r_inv_cnt <= w_inv_cnt_nx;
      r_chg     <= w_chg_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_level_nx   = r_level;
    w_inv_cnt_nx = r_inv_cnt;
    w_chg_nx     = 1'b0;
    if (r_state == FALHA) begin
      w_inv_cnt_nx = '0;
      if (w_code_valid && ack) begin
        w_state_nx = w_code_lvl;
        w_level_nx = w_code_lvl;
        w_chg_nx   = (w_code_lvl != r_level);
      end
    end else if (w_code_valid) begin
      w_inv_cnt_nx = '0;
      if (w_code_lvl != r_state) begin
        w_state_nx = w_code_lvl;
        w_level_nx = w_code_lvl;
        w_chg_nx   = 1'b1;
      end
    end else if (r_inv_cnt == INV_LAST) begin
      w_state_nx   = FALHA;
      w_inv_cnt_nx = '0;
    end else begin
      w_inv_cnt_nx = r_inv_cnt + IW'(1);
    end
  end

  always_comb begin
    A         = (r_level == ALTO);
    M         = (r_level == ALTO) || (r_level == MEDIO);
    B         = (r_level != VAZIO);
    valor_0   = (r_level == VAZIO);
    alarm     = (r_state == FALHA);
    level_chg = r_chg;
  end

endmodule

// File: tb/tb_nivel_sensor_cond.sv
// -----------------------------------------------------------------------------
// tb_nivel_sensor_cond
//   Self-checking bench for nivel_sensor_cond with DEB_CYCLES=4,
//   ALARM_CYCLES=3. A cycle-level reference model (sample history, run
//   lengths and an integer tank level) predicts every output each cycle;
//   directed sequences cover latency, glitch rejection, fault/ack handling,
//   multi-level jumps and asynchronous reset, followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_nivel_sensor_cond;

  localparam int DEB = 4;
  localparam int ALM = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sA = 1'b0, sM = 1'b0, sB = 1'b0, ack = 1'b0;
  logic A, M, B, alarm, valor_0, level_chg;

  nivel_sensor_cond #(.DEB_CYCLES(DEB), .ALARM_CYCLES(ALM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sA       (sA),
    .sM       (sM),
    .sB       (sB),
    .ack      (ack),
    .A        (A),
    .M        (M),
    .B        (B),
    .alarm    (alarm),
    .valor_0  (valor_0),
    .level_chg(level_chg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [2:0] hist_old = '0;   // raw sample two edges ago
  bit [2:0] hist_new = '0;   // raw sample one edge ago
  bit [2:0] m_deb = '0;
  int       m_run[3] = '{0, 0, 0};
  int       m_lvl = 0;       // 0 empty .. 3 full
  bit       m_fail = 1'b0;
  int       m_inv = 0;
  bit       m_chg = 1'b0;

  bit [2:0] mv_code;
  bit [2:0] mv_din;
  int       mv_ones;
  bit       mv_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_old = '0; hist_new = '0; m_deb = '0;
      m_run = '{0, 0, 0};
      m_lvl = 0; m_fail = 0; m_inv = 0; m_chg = 0;
    end else begin
      mv_code  = m_deb;
      mv_ones  = int'(mv_code[0]) + int'(mv_code[1]) + int'(mv_code[2]);
      mv_valid = (mv_code == 3'b000) || (mv_code == 3'b001) ||
                 (mv_code == 3'b011) || (mv_code == 3'b111);
      m_chg = 0;
      if (m_fail) begin
        if (mv_valid && ack) begin
          m_chg  = (mv_ones != m_lvl);
          m_lvl  = mv_ones;
          m_fail = 0;
        end
      end else if (mv_valid) begin
        m_chg = (mv_ones != m_lvl);
        m_lvl = mv_ones;
        m_inv = 0;
      end else begin
        m_inv++;
        if (m_inv == ALM) begin
          m_fail = 1;
          m_inv  = 0;
        end
      end
      mv_din   = hist_old;
      hist_old = hist_new;
      hist_new = {sA, sM, sB};
      for (int i = 0; i < 3; i++) begin
        if (mv_din[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_deb[i] = ~m_deb[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  function automatic logic [5:0] model_outs();
    return {m_lvl >= 3, m_lvl >= 2, m_lvl >= 1, m_lvl == 0, m_fail, m_chg};
  endfunction

  // Per-cycle comparison against the model, plus event counters.
  int chg_cnt    = 0;
  bit alarm_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle", {A, M, B, valor_0, alarm, level_chg}, model_outs());
      if (level_chg) chg_cnt++;
      if (alarm) alarm_seen = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int lat;
  int c0;
  int hold;
  int sel;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check("rst_outs", {A, M, B, valor_0, alarm, level_chg}, 6'b000100);
    #11 rst_n = 1'b1;

    // Idle after reset
    cyc(10);
    check("idle_outs", {A, M, B, valor_0, alarm, level_chg}, 6'b000100);
    check("idle_pulses", chg_cnt, 0);

    // VAZIO -> BAIXO latency
    sB  = 1'b1;
    lat = 0;
    repeat (20) begin
      @(posedge clk); #1;
      lat++;
      if (B) break;
    end
    check("latency", lat, DEB + 3);
    check("lat_chg", level_chg, 1);
    check("lat_v0", valor_0, 0);
    @(posedge clk); #1;
    check("chg_one_cycle", level_chg, 0);
    cyc(3);
    check("one_pulse", chg_cnt, 1);

    // Short sM glitch from BAIXO
    sM = 1'b1;
    cyc(3);
    sM = 1'b0;
    cyc(15);
    check("glitch_outs", {A, M, B, alarm}, 4'b0010);
    check("glitch_pulses", chg_cnt, 1);

    // MEDIO, then invalid 101 into FALHA
    sM = 1'b1;
    cyc(12);
    check("medio", {A, M, B}, 3'b011);
    sA = 1'b1; sM = 1'b0;
    cyc(15);
    check("falha", {A, M, B, alarm, valor_0}, 5'b01110);
    ack = 1'b1;
    cyc(3);
    check("ack_invalid", alarm, 1);
    ack = 1'b0;
    sM = 1'b1;
    cyc(12);
    check("hold_noack", {alarm, A, M, B}, 4'b1011);
    ack = 1'b1;
    @(posedge clk); #1;
    check("exit_falha", {A, M, B, alarm, level_chg}, 5'b11101);
    @(negedge clk) ack = 1'b0;

    // Back into FALHA from ALTO, then asynchronous reset mid-cycle
    sM = 1'b0;
    cyc(15);
    check("falha2", {alarm, A, M, B}, 4'b1111);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {A, M, B, valor_0, alarm, level_chg}, 6'b000100);
    sA = 1'b0; sM = 1'b0; sB = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("post_rst", {A, M, B, valor_0, alarm}, 5'b00010);

    // BAIXO -> ALTO jump with a 2-cycle invalid window
    sB = 1'b1;
    cyc(12);
    alarm_seen = 1'b0;
    c0 = chg_cnt;
    sA = 1'b1;
    cyc(2);
    sM = 1'b1;
    cyc(15);
    check("jump_outs", {A, M, B, alarm}, 4'b1110);
    check("jump_noalarm", alarm_seen, 0);
    check("jump_pulses", chg_cnt - c0, 1);

    // Random segments checked cycle by cycle against the model
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        case ($urandom_range(0, 3))
          0: {sA, sM, sB} = 3'b000;
          1: {sA, sM, sB} = 3'b001;
          2: {sA, sM, sB} = 3'b011;
          default: {sA, sM, sB} = 3'b111;
        endcase
      end else begin
        {sA, sM, sB} = 3'($urandom_range(0, 7));
      end
      ack  = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 14);
      cyc(hold);
    end
    ack = 1'b0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nivel_sensor_cond.md
Name: nivel_sensor_cond

Overview:
- Input-side conditioner for the irrigation tank level probes. Takes raw high (A), mid (M) and low (B) probe lines, synchronises and debounces them, and validates the probe combination.
- Produces the registered level code A/M/B, plus alarm and valor_0, consumed by the 7-segment display logic.
- Also produces a one-cycle level-change strobe for the pump controller.

Parameters:
- DEB_CYCLES, 16: consecutive agreeing synchronised samples required before a probe's debounced value changes (minimum 1).
- ALARM_CYCLES, 8: consecutive cycles an invalid debounced combination must persist before entering FALHA (minimum 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sA  input  1  raw high probe, 1 = water present, asynchronous to clk
- sM  input  1  raw mid probe, same convention
- sB  input  1  raw low probe, same convention
- ack  input  1  alarm acknowledge, synchronous, level-sampled
- A  output  1  conditioned high level
- M  output  1  conditioned mid level
- B  output  1  conditioned low level
- alarm  output  1  probe-fault alarm, sticky
- valor_0  output  1  tank empty indication
- level_chg  output  1  one-cycle pulse on each accepted level change

Behaviour:
- Reset: clk and rst_n are the only clock and reset.
  - On rst_n=0, all flops clear immediately.
  - State = VAZIO; A=M=B=0; alarm=0; valor_0=1; level_chg=0.
  - Debounced values and counters are 0; synchroniser flops are 0.
  - Reset mid-debounce or mid-FALHA discards all progress.
- Synchroniser: 2-flop synchroniser per probe input.
- Debounce (per probe, independent):
  - Counter counts while the synchronised value differs from the debounced value; it clears on any equal cycle.
  - When the counter would reach DEB_CYCLES, the debounced value flips and the counter clears.
  - Counter width is $clog2(DEB_CYCLES+1).
  - A glitch shorter than DEB_CYCLES cycles after synchronisation never propagates.
- Combination decode on debounced {a,m,b}:
  - 000 = VAZIO, 001 = BAIXO, 011 = MEDIO, 111 = ALTO.
  - All other codes are invalid.
- FSM states: VAZIO, BAIXO, MEDIO, ALTO, FALHA (registered).
- Valid level states:
  - On a valid code different from the current level, go to that level in the next cycle and pulse level_chg for that one cycle. Multi-level jumps (e.g. BAIXO to ALTO) are accepted.
  - On an invalid code, the invalid counter increments and the state holds.
  - When the counter reaches ALARM_CYCLES, enter FALHA.
  - Any valid cycle clears the invalid counter.
- FALHA:
  - alarm=1.
  - A/M/B hold the last valid level.
  - Exit requires a valid debounced code AND ack=1 in the same cycle; the next state is the level given by that code.
  - level_chg pulses on exit only if that level differs from the held level.
  - ack while the code is invalid is ignored. ack in non-FALHA states has no effect.
- Outputs (all registered, functions of the state register):
  - A/M/B = code of the current level, or the held level while in FALHA.
  - valor_0 = 1 iff the effective level is VAZIO; this applies in FALHA too.
  - alarm = 1 iff state is FALHA.
- Latency: a clean raw edge held steady appears on A/M/B, with the level_chg pulse, exactly DEB_CYCLES+3 clk edges after the first sampling edge (2 sync + DEB_CYCLES debounce + 1 FSM).
- Simultaneous events:
  - Probes that change together but settle in different cycles may produce transient invalid codes. These are tolerated unless they persist for ALARM_CYCLES.
  - Two valid level changes in consecutive cycles produce two separate level_chg pulses.
- No combinational path from any input to any output.

Test Plan (DEB_CYCLES=4, ALARM_CYCLES=3):
- Reset, then release with all probes 0 → A=M=B=0, valor_0=1, alarm=0, level_chg never pulses.
- From VAZIO, raise sB and hold → B=1 and valor_0=0 exactly 7 edges after the first sampling edge, with a single level_chg pulse at that edge.
- From BAIXO, pulse sM high for 3 cycles, then low → no output change, no level_chg.
- From MEDIO (011), force sA=1 and sM=0 (code 101) and hold → after debounce plus 3 invalid cycles, alarm=1 while A/M/B stay 011. ack asserted while still 101 keeps alarm=1. Restoring 111 then asserting ack → ALTO, A=M=B=1, alarm=0, one level_chg pulse.
- Jump BAIXO to ALTO by raising sM and sA 2 cycles apart → at most 2 cycles of invalid code, no alarm, final A=M=B=1, level_chg pulses once per accepted level.
- Assert rst_n=0 mid-FALHA → outputs return to reset values asynchronously, without waiting for a clk edge.
